// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB3 slave with NUM_REGS read/write registers, programmable wait states and pslverr.
// Byte-lane write strobes are added by defining APB_PSTRB_EN; without it every write is full-width.
module apb_reg_bank #(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter int                 NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int                 WAIT_STATES = 0,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0]          pstrb,
`endif
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt_p0;
  logic                wr_p0, err_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [STRB_W-1:0]   strb_p0;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [ADDR_W-1:0]   off, word;
  logic                dec_err, start, fire, commit;
  logic [STRB_W-1:0]   strb_in;
  logic [DATA_W-1:0]   prdata_nxt;
  logic [NUM_REGS-1:0] wr_pulse_nxt;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction

  // Address decode; an address below the base wraps off, so the explicit < check catches it
  always_comb begin
    off     = paddr - BASE_ADDR;
    word    = off >> 2;
    dec_err = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) || (word >= ADDR_W'(NUM_REGS));
  end

`ifdef APB_PSTRB_EN
  assign strb_in = pstrb;
`else
  assign strb_in = '1;
`endif

  assign start = (state == S_IDLE) && psel && penable;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (psel && penable) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!psel)             state_nxt = S_IDLE;
        else if (cnt_p0 == '0) state_nxt = S_RESP;
      end
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fire         = (state == S_WAIT) && psel && (cnt_p0 == '0);
    commit       = fire && wr_p0 && !err_p0;
    prdata_nxt   = '0;
    wr_pulse_nxt = '0;
    if (fire && !wr_p0 && !err_p0) prdata_nxt = regs[idx_p0];
    if (commit)                    wr_pulse_nxt[idx_p0] = 1'b1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // p0: request captured on the first access-phase cycle, counted down in WAIT
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_p0   <= '0;
      wr_p0    <= 1'b0;
      err_p0   <= 1'b0;
      idx_p0   <= '0;
      wdata_p0 <= '0;
      strb_p0  <= '0;
    end else if (start) begin
      cnt_p0   <= 4'(WAIT_STATES);
      wr_p0    <= pwrite;
      err_p0   <= dec_err;
      idx_p0   <= word[IDX_W-1:0];
      wdata_p0 <= pwdata;
      strb_p0  <= strb_in;
    end else if ((state == S_WAIT) && psel && (cnt_p0 != '0)) begin
      cnt_p0   <= cnt_p0 - 4'd1;
    end
  end

  // Response and register commit share the edge that raises pready
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      pready   <= fire;
      pslverr  <= fire && err_p0;
      prdata   <= prdata_nxt;
      wr_pulse <= wr_pulse_nxt;
      if (commit) regs[idx_p0] <= merge_bytes(regs[idx_p0], wdata_p0, strb_p0);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Testbench for apb_reg_bank: two instances (no wait states / base 0, and 3 wait states / base 0x100)
// checked against an address-matching register model with randomized traffic.
module tb_apb_reg_bank;

  localparam int          WS_A   = 0;
  localparam int          WS_B   = 3;
  localparam logic [31:0] BASE_A = 32'h0;
  localparam logic [31:0] BASE_B = 32'h100;
  localparam logic [31:0] RV_A   = 32'hA5;
  localparam logic [31:0] RV_B   = 32'h0;

  logic         pclk = 1'b0;
  logic         presetn;
  logic         psel_a, psel_b, penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata_a, prdata_b;
  logic         pready_a, pready_b, pslverr_a, pslverr_b;
  logic [255:0] reg_out_a, reg_out_b;
  logic [7:0]   wr_pulse_a, wr_pulse_b;

  always #5 pclk = ~pclk;

  apb_reg_bank #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .BASE_ADDR(BASE_A),
                 .WAIT_STATES(WS_A), .RESET_VAL(RV_A)) u_a (
    .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
    .reg_out(reg_out_a), .wr_pulse(wr_pulse_a));

  apb_reg_bank #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .BASE_ADDR(BASE_B),
                 .WAIT_STATES(WS_B), .RESET_VAL(RV_B)) u_b (
    .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
    .reg_out(reg_out_b), .wr_pulse(wr_pulse_b));

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_a [8];
  logic [31:0] model_b [8];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      model_a[i] = RV_A;
      model_b[i] = RV_B;
    end
  endtask

  // Register i answers exactly at base + 4*i; anything else is an error
  task automatic model_xfer(input bit b, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            output logic [31:0] exp_rd, output logic exp_err,
                            output logic [7:0] exp_wp);
    logic [31:0] base, cur;
    int hit;
    base = b ? BASE_B : BASE_A;
    hit = -1;
    for (int i = 0; i < 8; i++)
      if (addr == base + 32'(4 * i)) hit = i;
    exp_err = (hit < 0);
    exp_rd  = '0;
    exp_wp  = '0;
    if (hit >= 0) begin
      cur = b ? model_b[hit] : model_a[hit];
      if (wr) begin
        for (int k = 0; k < 4; k++) begin
`ifdef APB_PSTRB_EN
          if (strb[k]) cur[k*8 +: 8] = data[k*8 +: 8];
`else
          cur[k*8 +: 8] = data[k*8 +: 8];
`endif
        end
        if (b) model_b[hit] = cur; else model_a[hit] = cur;
        exp_wp[hit] = 1'b1;
      end else begin
        exp_rd = cur;
      end
    end
  endtask

  // One full APB3 transfer; lat counts edges after the first access-phase edge, -1 on timeout
  task automatic apb_xfer(input bit b, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rd, output logic err, output logic [7:0] wp,
                          output int lat, output logic rdy_after, output logic [7:0] wp_after);
    @(posedge pclk); #1;
    psel_a = !b; psel_b = b; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    lat = -1; rd = '0; err = 1'b0; wp = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge pclk); #1;
      if (b ? pready_b : pready_a) begin
        lat = n;
        rd  = b ? prdata_b : prdata_a;
        err = b ? pslverr_b : pslverr_a;
        wp  = b ? wr_pulse_b : wr_pulse_a;
        break;
      end
    end
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    rdy_after = b ? pready_b : pready_a;
    wp_after  = b ? wr_pulse_b : wr_pulse_a;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    vectors++;
    if (pready_a !== 1'b0 || pready_b !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pready: got a=%b b=%b expected 0", pready_a, pready_b);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (reg_out_a[i*32 +: 32] !== RV_A || reg_out_b[i*32 +: 32] !== RV_B) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got a=%h b=%h expected a=%h b=%h", i,
                 reg_out_a[i*32 +: 32], reg_out_b[i*32 +: 32], RV_A, RV_B);
      end
    end
    presetn = 1'b1;
    model_reset();
    @(posedge pclk); #1;
    vectors++;
    if (wr_pulse_a !== 8'h0 || prdata_a !== 32'h0 || pslverr_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got wp=%h rd=%h err=%b expected 0", wr_pulse_a, prdata_a, pslverr_a);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, erd; logic err, eerr, ra; logic [7:0] wp, ewp, wa; int lat;
    model_xfer(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, erd, eerr, ewp);
    apb_xfer(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, rd, err, wp, lat, ra, wa);
    vectors++;
    if (lat !== WS_A + 1) begin
      miscompares++;
      $display("FAIL wr_latency: got %0d expected %0d", lat, WS_A + 1);
    end
    vectors++;
    if (err !== 1'b0 || wp !== 8'b0000_0100) begin
      miscompares++;
      $display("FAIL wr_resp: got err=%b wp=%b expected err=0 wp=00000100", err, wp);
    end
    vectors++;
    if (ra !== 1'b0 || wa !== 8'h0) begin
      miscompares++;
      $display("FAIL wr_one_cycle: got pready=%b wp=%b expected 0", ra, wa);
    end
    model_xfer(0, 0, 32'h8, 32'h0, 4'hF, erd, eerr, ewp);
    apb_xfer(0, 0, 32'h8, 32'h0, 4'hF, rd, err, wp, lat, ra, wa);
    vectors++;
    if (rd !== 32'hDEADBEEF || erd !== 32'hDEADBEEF || err !== 1'b0 || wp !== 8'h0) begin
      miscompares++;
      $display("FAIL rd_data: got %h err=%b wp=%b expected deadbeef err=0 wp=0", rd, err, wp);
    end
  endtask

  task automatic test_wait_latency();
    logic [31:0] rd, erd; logic err, eerr, ra; logic [7:0] wp, ewp, wa; int lat;
    model_xfer(1, 0, BASE_B, 32'h0, 4'hF, erd, eerr, ewp);
    apb_xfer(1, 0, BASE_B, 32'h0, 4'hF, rd, err, wp, lat, ra, wa);
    vectors++;
    if (lat !== 4 || ra !== 1'b0) begin
      miscompares++;
      $display("FAIL ws3_latency: got lat=%0d pready_after=%b expected lat=4 pready_after=0", lat, ra);
    end
    vectors++;
    if (rd !== erd || err !== 1'b0) begin
      miscompares++;
      $display("FAIL ws3_read: got %h err=%b expected %h err=0", rd, err, erd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic err, eerr, ra; logic [7:0] wp, ewp, wa; int lat;
    logic [31:0] addrs [4];
    bit          inst [4];
    bit          wrs [4];
    addrs = '{32'h20, 32'h6, 32'h20, 32'hFC};
    inst  = '{0, 0, 0, 1};
    wrs   = '{1, 1, 0, 1};
    for (int t = 0; t < 4; t++) begin
      model_xfer(inst[t], wrs[t], addrs[t], 32'hCAFE0000 + 32'(t), 4'hF, erd, eerr, ewp);
      apb_xfer(inst[t], wrs[t], addrs[t], 32'hCAFE0000 + 32'(t), 4'hF, rd, err, wp, lat, ra, wa);
      vectors++;
      if (err !== 1'b1 || eerr !== 1'b1 || rd !== 32'h0 || wp !== 8'h0) begin
        miscompares++;
        $display("FAIL err_resp@%h: got err=%b rd=%h wp=%b expected err=1 rd=0 wp=0",
                 addrs[t], err, rd, wp);
      end
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if ((inst[t] ? reg_out_b[i*32 +: 32] : reg_out_a[i*32 +: 32]) !==
            (inst[t] ? model_b[i] : model_a[i])) begin
          miscompares++;
          $display("FAIL err_nochange@%h reg%0d: got %h expected %h", addrs[t], i,
                   inst[t] ? reg_out_b[i*32 +: 32] : reg_out_a[i*32 +: 32],
                   inst[t] ? model_b[i] : model_a[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    @(posedge pclk); #1;
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE_B + 32'h4;
    pwdata = 32'h5555AAAA; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    psel_b = 1'b0; penable = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge pclk); #1;
      vectors++;
      if (pready_b !== 1'b0 || wr_pulse_b !== 8'h0) begin
        miscompares++;
        $display("FAIL abort_cycle%0d: got pready=%b wp=%b expected 0", n, pready_b, wr_pulse_b);
      end
    end
    vectors++;
    if (reg_out_b[32 +: 32] !== model_b[1]) begin
      miscompares++;
      $display("FAIL abort_reg1: got %h expected %h", reg_out_b[32 +: 32], model_b[1]);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, erd; logic err, eerr, ra; logic [7:0] wp, ewp, wa; int lat;
    model_xfer(0, 1, 32'hC, 32'h12345678, 4'hF, erd, eerr, ewp);
    apb_xfer(0, 1, 32'hC, 32'h12345678, 4'hF, rd, err, wp, lat, ra, wa);
    @(posedge pclk); #1;
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE_B + 32'h8; pwdata = 32'h77; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b0;
    #2;
    model_reset();
    vectors++;
    if (pready_b !== 1'b0 || wr_pulse_b !== 8'h0 || wr_pulse_a !== 8'h0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: got pready=%b wp_b=%b wp_a=%b expected 0", pready_b, wr_pulse_b, wr_pulse_a);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (reg_out_a[i*32 +: 32] !== model_a[i] || reg_out_b[i*32 +: 32] !== model_b[i]) begin
        miscompares++;
        $display("FAIL midreset_reg%0d: got a=%h b=%h expected a=%h b=%h", i,
                 reg_out_a[i*32 +: 32], reg_out_b[i*32 +: 32], model_a[i], model_b[i]);
      end
    end
    psel_b = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    repeat (6) @(posedge pclk);
    #1;
    vectors++;
    if (pready_b !== 1'b0 || reg_out_b[64 +: 32] !== model_b[2]) begin
      miscompares++;
      $display("FAIL midreset_release: got pready=%b reg2=%h expected 0 %h", pready_b, reg_out_b[64 +: 32], model_b[2]);
    end
  endtask

`ifdef APB_PSTRB_EN
  task automatic test_pstrb();
    logic [31:0] rd, erd; logic err, eerr, ra; logic [7:0] wp, ewp, wa; int lat;
    model_xfer(0, 1, 32'h8, 32'h11223344, 4'hF, erd, eerr, ewp);
    apb_xfer(0, 1, 32'h8, 32'h11223344, 4'hF, rd, err, wp, lat, ra, wa);
    model_xfer(0, 1, 32'h8, 32'hAABBCCDD, 4'b0101, erd, eerr, ewp);
    apb_xfer(0, 1, 32'h8, 32'hAABBCCDD, 4'b0101, rd, err, wp, lat, ra, wa);
    vectors++;
    if (reg_out_a[64 +: 32] !== 32'h11BB33DD || err !== 1'b0) begin
      miscompares++;
      $display("FAIL pstrb_0101: got %h err=%b expected 11bb33dd err=0", reg_out_a[64 +: 32], err);
    end
    model_xfer(0, 1, 32'h8, 32'hFFFFFFFF, 4'b0000, erd, eerr, ewp);
    apb_xfer(0, 1, 32'h8, 32'hFFFFFFFF, 4'b0000, rd, err, wp, lat, ra, wa);
    vectors++;
    if (reg_out_a[64 +: 32] !== 32'h11BB33DD || err !== 1'b0 || wp !== 8'b0000_0100) begin
      miscompares++;
      $display("FAIL pstrb_0000: got %h err=%b wp=%b expected 11bb33dd err=0 wp=00000100",
               reg_out_a[64 +: 32], err, wp);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rd, erd, addr, data, base; logic err, eerr, ra; logic [7:0] wp, ewp, wa;
    logic [3:0] strb; int lat, kind; bit b, wr;
    for (int t = 0; t < 60; t++) begin
      b    = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 4);
      base = b ? BASE_B : BASE_A;
      data = $urandom;
      strb = 4'($urandom);
      case (kind)
        0, 1: addr = base + 32'(4 * $urandom_range(0, 7));
        2:    addr = base + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
        3:    addr = base + 32'h20 + 32'(4 * $urandom_range(0, 15));
        default: addr = base - 32'(4 * $urandom_range(1, 8));
      endcase
      model_xfer(b, wr, addr, data, strb, erd, eerr, ewp);
      apb_xfer(b, wr, addr, data, strb, rd, err, wp, lat, ra, wa);
      vectors++;
      if (lat !== (b ? WS_B : WS_A) + 1 || err !== eerr || rd !== erd || wp !== ewp) begin
        miscompares++;
        $display("FAIL rand%0d %s@%h: got lat=%0d err=%b rd=%h wp=%b expected lat=%0d err=%b rd=%h wp=%b",
                 t, wr ? "wr" : "rd", addr, lat, err, rd, wp, (b ? WS_B : WS_A) + 1, eerr, erd, ewp);
      end
      vectors++;
      if (ra !== 1'b0 || wa !== 8'h0) begin
        miscompares++;
        $display("FAIL rand%0d_tail: got pready=%b wp=%b expected 0", t, ra, wa);
      end
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (reg_out_a[i*32 +: 32] !== model_a[i] || reg_out_b[i*32 +: 32] !== model_b[i]) begin
          miscompares++;
          $display("FAIL rand%0d_reg%0d: got a=%h b=%h expected a=%h b=%h", t, i,
                   reg_out_a[i*32 +: 32], reg_out_b[i*32 +: 32], model_a[i], model_b[i]);
        end
      end
    end
  endtask

  initial begin
    presetn = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_wait_latency();
    test_errors();
    test_abort();
    test_reset_mid_wait();
`ifdef APB_PSTRB_EN
    test_pstrb();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
